// File: rtl/riscv_idecode_if.sv
// Fetch-to-decode handshake: instruction/pc and stall/flush in, decoded fields and control out.
interface riscv_idecode_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            stall;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] regfile_rs1;
  logic [XLEN-1:0] regfile_rs2;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_out;
  logic [3:0]      alu_op;
  logic            trap;
  logic [3:0]      trap_cause;
  logic [11:0]     csr_addr;
  logic            is_csr;
  logic            csr_read;
  logic            csr_write;
  logic            reg_write_enable;
  logic            mem_read;
  logic            mem_write;
  logic            is_branch;
  logic            jump;
  logic            use_pc;

  modport master (
    output flush, stall, instr, pc, regfile_rs1, regfile_rs2,
    input  opcode, rd, rs1, rs2, funct3, funct7, imm, pc_out, alu_op, trap, trap_cause,
           csr_addr, is_csr, csr_read, csr_write, reg_write_enable, mem_read, mem_write,
           is_branch, jump, use_pc
  );

  modport slave (
    input  flush, stall, instr, pc, regfile_rs1, regfile_rs2,
    output opcode, rd, rs1, rs2, funct3, funct7, imm, pc_out, alu_op, trap, trap_cause,
           csr_addr, is_csr, csr_read, csr_write, reg_write_enable, mem_read, mem_write,
           is_branch, jump, use_pc
  );
endinterface

// File: rtl/riscv_idecode.sv
// RV64I + Zicsr decode stage: fields, immediate, ALU op, control and trap flags.
// One-cycle latency; stall holds every registered output, flush loads an all-zero bubble.
module riscv_idecode #(
  parameter int XLEN = 64
) (
  input logic            clk,
  input logic            reset,
  riscv_idecode_if.slave bus
);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8, ALU_AND = 4'd9, ALU_SLTU = 4'd10;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2, CAUSE_EBREAK = 4'd3, CAUSE_ECALL = 4'd11;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_out;
    logic [3:0]      alu_op;
    logic            trap;
    logic [3:0]      trap_cause;
    logic [11:0]     csr_addr;
    logic            is_csr;
    logic            csr_read;
    logic            csr_write;
    logic            reg_write_enable;
    logic            mem_read;
    logic            mem_write;
    logic            is_branch;
    logic            jump;
    logic            use_pc;
  } dec_t;

  dec_t            d, q;
  logic            illegal;
  logic [31:0]     ins;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            word_ok;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic            unused_rf;

  assign ins   = bus.instr;
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'h000};

  // ins[3] marks the *-32 opcodes, which only exist on RV64 and only for ADD/SUB/shifts
  assign word_ok = !ins[3] || (RV64 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101));

  assign unused_rf = ^{bus.regfile_rs1, bus.regfile_rs2};

  function automatic logic [3:0] alu_sel(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  always_comb begin
    d          = '0;
    illegal    = 1'b0;
    d.opcode   = ins[6:0];
    d.rd       = ins[11:7];
    d.rs1      = ins[19:15];
    d.rs2      = ins[24:20];
    d.funct3   = f3;
    d.funct7   = f7;
    d.pc_out   = bus.pc;
    d.csr_addr = ins[31:20];
    if (ins[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (ins[6:0])
        OPC_OP, OPC_OP_32: begin
          d.reg_write_enable = 1'b1;
          if (!word_ok) illegal = 1'b1;
          else if (f7 == 7'b0000000) d.alu_op = alu_sel(f3, 1'b0);
          else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) d.alu_op = alu_sel(f3, 1'b1);
          else illegal = 1'b1;
        end
        OPC_OP_IMM, OPC_OP_IMM_32: begin
          d.reg_write_enable = 1'b1;
          d.imm              = imm_i;
          if (!word_ok) illegal = 1'b1;
          else case (f3)
            3'b001: if (ins[31:26] == 6'b000000) d.alu_op = ALU_SLL; else illegal = 1'b1;
            3'b101: begin
              if (ins[31:26] == 6'b000000) d.alu_op = ALU_SRL;
              else if (ins[31:26] == 6'b010000) d.alu_op = ALU_SRA;
              else illegal = 1'b1;
            end
            default: d.alu_op = alu_sel(f3, 1'b0);
          endcase
        end
        OPC_LOAD: begin
          d.reg_write_enable = 1'b1;
          d.mem_read         = 1'b1;
          d.alu_op           = ALU_ADD;
          d.imm              = imm_i;
          illegal            = (f3 == 3'b111) || (f3 == 3'b011 && !RV64);
        end
        OPC_STORE: begin
          d.mem_write = 1'b1;
          d.alu_op    = ALU_ADD;
          d.imm       = imm_s;
          illegal     = f3[2] || (f3 == 3'b011 && !RV64);
        end
        OPC_BRANCH: begin
          d.is_branch = 1'b1;
          d.imm       = imm_b;
          illegal     = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OPC_JAL: begin
          d.reg_write_enable = 1'b1;
          d.jump             = 1'b1;
          d.use_pc           = 1'b1;
          d.alu_op           = ALU_ADD;
          d.imm              = imm_j;
        end
        OPC_JALR: begin
          d.reg_write_enable = 1'b1;
          d.jump             = 1'b1;
          d.alu_op           = ALU_ADD;
          d.imm              = imm_i;
          illegal            = (f3 != 3'b000);
        end
        OPC_LUI: begin
          d.reg_write_enable = 1'b1;
          d.imm              = imm_u;
        end
        OPC_AUIPC: begin
          d.reg_write_enable = 1'b1;
          d.use_pc           = 1'b1;
          d.alu_op           = ALU_ADD;
          d.imm              = imm_u;
        end
        OPC_MISC_MEM: ;
        OPC_SYSTEM: begin
          d.imm = imm_i;
          if (f3 == 3'b000) begin
            if (ins == 32'h0000_0073) begin
              d.trap       = 1'b1;
              d.trap_cause = CAUSE_ECALL;
            end else if (ins == 32'h0010_0073) begin
              d.trap       = 1'b1;
              d.trap_cause = CAUSE_EBREAK;
            end else begin
              illegal = 1'b1;
            end
          end else if (f3 == 3'b100) begin
            illegal = 1'b1;
          end else begin
            // CSRRW/CSRRWI always write; set/clear forms write only with a nonzero rs1/uimm
            d.is_csr           = 1'b1;
            d.reg_write_enable = 1'b1;
            d.csr_read         = 1'b1;
            d.csr_write        = (f3[1:0] == 2'b01) || (ins[19:15] != 5'd0);
          end
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) begin
      d.imm              = '0;
      d.alu_op           = ALU_NONE;
      d.is_csr           = 1'b0;
      d.csr_read         = 1'b0;
      d.csr_write        = 1'b0;
      d.reg_write_enable = 1'b0;
      d.mem_read         = 1'b0;
      d.mem_write        = 1'b0;
      d.is_branch        = 1'b0;
      d.jump             = 1'b0;
      d.use_pc           = 1'b0;
      d.trap             = 1'b1;
      d.trap_cause       = CAUSE_ILLEGAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          q <= '0;
    else if (bus.flush) q <= '0;
    else if (!bus.stall) q <= d;
  end

  assign bus.opcode           = q.opcode;
  assign bus.rd               = q.rd;
  assign bus.rs1              = q.rs1;
  assign bus.rs2              = q.rs2;
  assign bus.funct3           = q.funct3;
  assign bus.funct7           = q.funct7;
  assign bus.imm              = q.imm;
  assign bus.pc_out           = q.pc_out;
  assign bus.alu_op           = q.alu_op;
  assign bus.trap             = q.trap;
  assign bus.trap_cause       = q.trap_cause;
  assign bus.csr_addr         = q.csr_addr;
  assign bus.is_csr           = q.is_csr;
  assign bus.csr_read         = q.csr_read;
  assign bus.csr_write        = q.csr_write;
  assign bus.reg_write_enable = q.reg_write_enable;
  assign bus.mem_read         = q.mem_read;
  assign bus.mem_write        = q.mem_write;
  assign bus.is_branch        = q.is_branch;
  assign bus.jump             = q.jump;
  assign bus.use_pc           = q.use_pc;
endmodule

// File: tb/tb_riscv_idecode.sv
// Bench for riscv_idecode: instruction-level reference model compared every cycle, plus literal pins.
module tb_riscv_idecode;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;

  riscv_idecode_if #(.XLEN(64)) bus ();

  riscv_idecode #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [63:0] pc_out;
    logic [3:0]  alu_op;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [11:0] csr_addr;
    logic        is_csr;
    logic        csr_read;
    logic        csr_write;
    logic        reg_write_enable;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        jump;
    logic        use_pc;
  } obs_t;

  obs_t       act;
  obs_t       exp_q;
  logic [8:0] ctrl;

  assign act = {bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.imm, bus.pc_out,
                bus.alu_op, bus.trap, bus.trap_cause, bus.csr_addr, bus.is_csr, bus.csr_read,
                bus.csr_write, bus.reg_write_enable, bus.mem_read, bus.mem_write, bus.is_branch,
                bus.jump, bus.use_pc};
  // {reg_write, mem_read, mem_write, branch, jump, use_pc, is_csr, csr_read, csr_write}
  assign ctrl = {bus.reg_write_enable, bus.mem_read, bus.mem_write, bus.is_branch, bus.jump,
                 bus.use_pc, bus.is_csr, bus.csr_read, bus.csr_write};

  // Reference decode of one instruction from the ISA tables, written per mnemonic class.
  function automatic obs_t model(input logic [31:0] i, input logic [63:0] p);
    obs_t       o;
    obs_t       r;
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] base [8];
    logic [63:0] ii, is, ib, ij, iu;
    base = '{4'd1, 4'd3, 4'd4, 4'd10, 4'd5, 4'd6, 4'd8, 4'd9};
    ii = longint'($signed(i[31:20]));
    is = longint'($signed({i[31:25], i[11:7]}));
    ib = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    ij = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    iu = longint'($signed({i[31:12], 12'h000}));
    f3 = i[14:12];
    f7 = i[31:25];
    o = '0;
    bad = 1'b0;
    o.opcode = i[6:0]; o.rd = i[11:7]; o.rs1 = i[19:15]; o.rs2 = i[24:20];
    o.funct3 = f3; o.funct7 = f7; o.pc_out = p; o.csr_addr = i[31:20];
    if (i[1:0] != 2'b11) bad = 1'b1;
    else case (i[6:0])
      7'b0110011, 7'b0111011: begin
        o.reg_write_enable = 1'b1;
        if (i[3] && !(f3 inside {3'd0, 3'd1, 3'd5})) bad = 1'b1;
        else if (f7 == 7'h00) o.alu_op = base[f3];
        else if (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) o.alu_op = base[f3] + 4'd1;
        else bad = 1'b1;
      end
      7'b0010011, 7'b0011011: begin
        o.reg_write_enable = 1'b1; o.imm = ii;
        if (i[3] && !(f3 inside {3'd0, 3'd1, 3'd5})) bad = 1'b1;
        else if (f3 == 3'd1) begin o.alu_op = 4'd3; bad = (i[31:26] != 6'd0); end
        else if (f3 == 3'd5) begin
          if (i[31:26] == 6'd0) o.alu_op = 4'd6;
          else if (i[31:26] == 6'b010000) o.alu_op = 4'd7;
          else bad = 1'b1;
        end
        else o.alu_op = base[f3];
      end
      7'b0000011: begin
        o.reg_write_enable = 1'b1; o.mem_read = 1'b1; o.alu_op = 4'd1; o.imm = ii; bad = (f3 == 3'd7);
      end
      7'b0100011: begin o.mem_write = 1'b1; o.alu_op = 4'd1; o.imm = is; bad = (f3 >= 3'd4); end
      7'b1100011: begin o.is_branch = 1'b1; o.imm = ib; bad = (f3 == 3'd2 || f3 == 3'd3); end
      7'b1101111: begin
        o.reg_write_enable = 1'b1; o.jump = 1'b1; o.use_pc = 1'b1; o.alu_op = 4'd1; o.imm = ij;
      end
      7'b1100111: begin
        o.reg_write_enable = 1'b1; o.jump = 1'b1; o.alu_op = 4'd1; o.imm = ii; bad = (f3 != 3'd0);
      end
      7'b0110111: begin o.reg_write_enable = 1'b1; o.imm = iu; end
      7'b0010111: begin o.reg_write_enable = 1'b1; o.use_pc = 1'b1; o.alu_op = 4'd1; o.imm = iu; end
      7'b0001111: ;
      7'b1110011: begin
        o.imm = ii;
        if (i == 32'h0000_0073) begin o.trap = 1'b1; o.trap_cause = 4'd11; end
        else if (i == 32'h0010_0073) begin o.trap = 1'b1; o.trap_cause = 4'd3; end
        else if (f3 == 3'd0 || f3 == 3'd4) bad = 1'b1;
        else begin
          o.is_csr = 1'b1; o.reg_write_enable = 1'b1; o.csr_read = 1'b1;
          o.csr_write = (f3 == 3'd1 || f3 == 3'd5) || (i[19:15] != 5'd0);
        end
      end
      default: bad = 1'b1;
    endcase
    if (!bad) return o;
    r = '0;
    r.opcode = o.opcode; r.rd = o.rd; r.rs1 = o.rs1; r.rs2 = o.rs2;
    r.funct3 = o.funct3; r.funct7 = o.funct7; r.pc_out = p; r.csr_addr = o.csr_addr;
    r.trap = 1'b1; r.trap_cause = 4'd2;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset)          exp_q <= '0;
    else if (bus.flush) exp_q <= '0;
    else if (!bus.stall) exp_q <= model(bus.instr, bus.pc);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (act !== exp_q) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, act, exp_q);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic [63:0] p);
    bus.instr = i;
    bus.pc    = p;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] extra [] = '{
    32'h4010D093, 32'h80109093, 32'h00812083, 32'h00813083, 32'h00817083, 32'h00C24623,
    32'h00C23623, 32'h0020A863, 32'hFE209EE3, 32'h000100E7, 32'h000110E7, 32'hFFFFF097,
    32'h0FF0000F, 32'h003100BB, 32'h403100BB, 32'h023100BB, 32'h003120BB, 32'hFFF1009B,
    32'h4010D09B, 32'h0011209B, 32'h00000001, 32'h00000000, 32'h30014073, 32'h10500073,
    32'h3002E0F3, 32'h300070F3, 32'h003130B3, 32'h003170B3, 32'h403150B3, 32'h403110B3,
    32'h023100B3, 32'h0000005B, 32'h00100073, 32'h300050F3
  };

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0; bus.stall = 1'b0;
    bus.instr = 32'h0; bus.pc = 64'h0;
    bus.regfile_rs1 = 64'h0; bus.regfile_rs2 = 64'h0;
    #1 reset = 1'b1;
    #1;
    chk("reset_alu_op", {60'd0, bus.alu_op}, 64'd0);
    chk("reset_pc_out", bus.pc_out, 64'd0);
    chk("reset_ctrl", {55'd0, ctrl}, 64'd0);
    chk("reset_trap", {59'd0, bus.trap, bus.trap_cause}, 64'd0);
    cmp_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    issue(32'h003100B3, 64'h8000_0000_0000_1000);
    chk("add_alu_op", {60'd0, bus.alu_op}, 64'd1);
    chk("add_ctrl", {55'd0, ctrl}, 64'h100);
    chk("add_regs", {49'd0, bus.rd, bus.rs1, bus.rs2}, {49'd0, 5'd1, 5'd2, 5'd3});
    chk("add_pc_out", bus.pc_out, 64'h8000_0000_0000_1000);
    issue(32'h40628233, 64'h1004);
    chk("sub_alu_op", {60'd0, bus.alu_op}, 64'd2);
    chk("sub_ctrl", {55'd0, ctrl}, 64'h100);
    issue(32'h06400093, 64'h1008);
    chk("addi_imm", bus.imm, 64'h64);
    issue(32'hFFF0C113, 64'h100C);
    chk("xori_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("xori_alu_op", {60'd0, bus.alu_op}, 64'd5);
    issue(32'h00C22623, 64'h1010);
    chk("sw_ctrl", {55'd0, ctrl}, 64'h040);
    chk("sw_imm", bus.imm, 64'hC);
    issue(32'h00208863, 64'h1014);
    chk("beq_ctrl", {55'd0, ctrl}, 64'h020);
    chk("beq_imm", bus.imm, 64'h10);
    issue(32'h008000EF, 64'h1018);
    chk("jal_ctrl", {55'd0, ctrl}, 64'h118);
    chk("jal_imm", bus.imm, 64'h8);
    issue(32'h123450B7, 64'h101C);
    chk("lui_imm", bus.imm, 64'h1234_5000);
    chk("lui_alu_op", {60'd0, bus.alu_op}, 64'd0);
    issue(32'h300110F3, 64'h1020);
    chk("csrrw_ctrl", {55'd0, ctrl}, 64'h107);
    chk("csrrw_addr", {52'd0, bus.csr_addr}, 64'h300);
    issue(32'h300020F3, 64'h1024);
    chk("csrrs_x0_ctrl", {55'd0, ctrl}, 64'h106);
    issue(32'h00000073, 64'h1028);
    chk("ecall_trap", {59'd0, bus.trap, bus.trap_cause}, {59'd0, 1'b1, 4'd11});
    chk("ecall_ctrl", {55'd0, ctrl}, 64'd0);
    issue(32'hFFFFFFFF, 64'h102C);
    chk("illegal_trap", {59'd0, bus.trap, bus.trap_cause}, {59'd0, 1'b1, 4'd2});
    chk("illegal_ctrl", {55'd0, ctrl, bus.alu_op}, 64'd0);

    for (int k = 0; k < extra.size(); k++) issue(extra[k], 64'h2000 + 64'(4 * k));

    issue(32'h003100B3, 64'h3000);
    bus.stall = 1'b1;
    issue(32'h40628233, 64'h3004);
    chk("stall_alu_op", {60'd0, bus.alu_op}, 64'd1);
    chk("stall_pc_out", bus.pc_out, 64'h3000);
    issue(32'hFFF0C113, 64'h3008);
    chk("stall2_rd", {59'd0, bus.rd}, 64'd1);
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    issue(32'h40628233, 64'h300C);
    chk("flush_bubble", {55'd0, ctrl}, 64'd0);
    chk("flush_fields", {32'd0, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7}, 64'd0);
    chk("flush_pc_out", bus.pc_out, 64'd0);
    bus.flush = 1'b0;
    issue(32'h40628233, 64'h3010);
    chk("post_flush_alu_op", {60'd0, bus.alu_op}, 64'd2);
    bus.flush = 1'b1; bus.stall = 1'b1;
    issue(32'h008000EF, 64'h3014);
    chk("flush_over_stall", {51'd0, ctrl, bus.alu_op}, 64'd0);
    bus.flush = 1'b0; bus.stall = 1'b0;
    issue(32'h008000EF, 64'h3018);
    chk("post_flush_stall_jal", {55'd0, ctrl}, 64'h118);

    reset = 1'b1;
    #1;
    chk("midreset_ctrl", {51'd0, ctrl, bus.alu_op}, 64'd0);
    chk("midreset_imm", bus.imm, 64'd0);
    chk("midreset_pc_out", bus.pc_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(32'h00100073, 64'h4000);
    chk("ebreak_trap", {59'd0, bus.trap, bus.trap_cause}, {59'd0, 1'b1, 4'd3});
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
